// File: rtl/btn_evt_pkg.sv
// -----------------------------------------------------------------------------
// btn_evt_pkg
// Shared definitions for the pushbutton event arbiter:
//   - btn_evt_state_t : offer FSM state encoding (ST_IDLE / ST_OFFER)
//   - BTN_N_DEFAULT   : default number of pushbutton inputs
//   - BTN_HOLD_DEFAULT / BTN_REPEAT_DEFAULT : default auto-repeat timing
//   - btn_max()       : helper used to size the shared repeat counter
// -----------------------------------------------------------------------------
package btn_evt_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } btn_evt_state_t;

    localparam int BTN_N_DEFAULT      = 4;
    localparam int BTN_HOLD_DEFAULT   = 50_000_000;
    localparam int BTN_REPEAT_DEFAULT = 10_000_000;

    function automatic int btn_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// -----------------------------------------------------------------------------
// btn_edge_sync
// One pushbutton lane: 2-flop synchronizer followed by a registered
// rising-edge detector. RISE is one cycle wide, three cycles after PB rises.
//
// Ports:
//   CLOCK   in  1  clock, rising edge
//   RESET_N in  1  asynchronous active-low reset
//   PB      in  1  raw asynchronous button level (1 = pressed)
//   LEVEL   out 1  synchronized button level
//   RISE    out 1  one-cycle rising-edge pulse
// -----------------------------------------------------------------------------
module btn_edge_sync (
    input  logic CLOCK,
    input  logic RESET_N,
    input  logic PB,
    output logic LEVEL,
    output logic RISE
);

    logic       sync_p0;
    logic       sync_p1;
    logic       prev_p2;
    logic       rise_p2;
    logic [1:0] warm_cnt;
    logic       armed;

    // The synchronizer flops restart at 0, so a button held through reset
    // release would look like a fresh rise. The detector stays disarmed until
    // prev has loaded the true synced level.
    assign armed = (warm_cnt == 2'd3);

    // Stage p0/p1: two-flop synchronizer
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= PB;
            sync_p1 <= sync_p0;
        end
    end

    // Stage p2: registered rising-edge detect
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            prev_p2  <= 1'b0;
            rise_p2  <= 1'b0;
            warm_cnt <= 2'd0;
        end else begin
            prev_p2 <= sync_p1;
            rise_p2 <= armed & sync_p1 & ~prev_p2;
            if (!armed) begin
                warm_cnt <= warm_cnt + 2'd1;
            end
        end
    end

    assign LEVEL = sync_p1;
    assign RISE  = rise_p2;

endmodule

// File: rtl/button_event_arbiter.sv
// -----------------------------------------------------------------------------
// button_event_arbiter
// Turns N_BTN raw pushbuttons into a stream of button-ID events with a
// valid/ready handshake. Each button has a pending flag; a round-robin
// arbiter picks the next pending button after the last one granted.
// A press that arrives while its button is still pending is dropped and
// reported on DROP_PULSE.
//
// Optional feature: define BTN_AUTO_REPEAT_EN to generate auto-repeat
// pulses for the lowest-index held button (first after HOLD_CYCLES, then
// every REPEAT_CYCLES). Without the macro only rising edges make events.
//
// Parameters:
//   N_BTN         number of buttons (2..8)
//   ID_W          event ID width, clog2(N_BTN)
//   HOLD_CYCLES   auto-repeat initial delay
//   REPEAT_CYCLES auto-repeat period
//
// Ports:
//   CLOCK      in  1      clock, rising edge
//   RESET_N    in  1      asynchronous active-low reset
//   PB         in  N_BTN  raw button levels, 1 = pressed
//   EVT_VALID  out 1      event offered
//   EVT_ID     out ID_W   index of the offered button
//   EVT_READY  in  1      consumer accepts the offered event
//   PENDING    out N_BTN  registered per-button pending flags
//   DROP_PULSE out 1      one-cycle pulse when a press is lost
// -----------------------------------------------------------------------------
module button_event_arbiter
    import btn_evt_pkg::*;
#(
    parameter int N_BTN         = BTN_N_DEFAULT,
    parameter int ID_W          = $clog2(N_BTN),
    parameter int HOLD_CYCLES   = BTN_HOLD_DEFAULT,
    parameter int REPEAT_CYCLES = BTN_REPEAT_DEFAULT
) (
    input  logic             CLOCK,
    input  logic             RESET_N,
    input  logic [N_BTN-1:0] PB,
    output logic             EVT_VALID,
    output logic [ID_W-1:0]  EVT_ID,
    input  logic             EVT_READY,
    output logic [N_BTN-1:0] PENDING,
    output logic             DROP_PULSE
);

    btn_evt_state_t   state;
    btn_evt_state_t   state_nxt;

    logic [N_BTN-1:0] sync_lvl;
    logic [N_BTN-1:0] edge_vec;
    logic [N_BTN-1:0] rpt_vec;
    logic [N_BTN-1:0] evt_vec;
    logic [N_BTN-1:0] req_vec;
    logic [N_BTN-1:0] clr_vec;
    logic [N_BTN-1:0] drop_vec;
    logic [N_BTN-1:0] pending_nxt;
    logic [ID_W-1:0]  last_grant;
    logic [ID_W-1:0]  grant_id;
    logic             hs;

    // First requesting index searching upward from last+1, wrapping to 0.
    function automatic logic [ID_W-1:0] rr_pick(input logic [N_BTN-1:0] req,
                                                input logic [ID_W-1:0]  last);
        logic [ID_W-1:0] pick;
        logic            found;
        int              idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= N_BTN; k++) begin
            idx = (int'(last) + k) % N_BTN;
            if (!found && req[idx]) begin
                pick  = ID_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Stage p0..p2: per-button synchronizer and edge detector
    for (genvar i = 0; i < N_BTN; i++) begin : g_sync
        btn_edge_sync u_sync (
            .CLOCK   (CLOCK),
            .RESET_N (RESET_N),
            .PB      (PB[i]),
            .LEVEL   (sync_lvl[i]),
            .RISE    (edge_vec[i])
        );
    end

`ifdef BTN_AUTO_REPEAT_EN
    localparam int CNT_MAX = btn_max(HOLD_CYCLES, REPEAT_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic [CNT_W-1:0] rpt_cnt;
    logic             rpt_trk;
    logic             rpt_phase;
    logic [ID_W-1:0]  rpt_id;
    logic [ID_W-1:0]  held_id;
    logic             any_held;
    logic             rpt_restart;
    logic             rpt_hit;

    // Lowest-index held button owns the single shared counter.
    always_comb begin
        held_id  = '0;
        any_held = 1'b0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (sync_lvl[i]) begin
                held_id  = ID_W'(i);
                any_held = 1'b1;
            end
        end
    end

    // The counter restarts one cycle before the edge pulse (the synced level
    // leads the registered edge by one cycle), so it reads 0 in the edge cycle.
    assign rpt_restart = !rpt_trk || (held_id != rpt_id);
    assign rpt_hit     = any_held && !rpt_restart &&
                         (rpt_cnt == (rpt_phase ? CNT_W'(REPEAT_CYCLES)
                                                : CNT_W'(HOLD_CYCLES)));

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            rpt_cnt   <= '0;
            rpt_trk   <= 1'b0;
            rpt_phase <= 1'b0;
            rpt_id    <= '0;
        end else if (!any_held) begin
            rpt_cnt   <= '0;
            rpt_trk   <= 1'b0;
            rpt_phase <= 1'b0;
        end else if (rpt_restart) begin
            rpt_cnt   <= '0;
            rpt_trk   <= 1'b1;
            rpt_phase <= 1'b0;
            rpt_id    <= held_id;
        end else if (rpt_hit) begin
            rpt_cnt   <= CNT_W'(1);
            rpt_phase <= 1'b1;
        end else begin
            rpt_cnt   <= rpt_cnt + CNT_W'(1);
        end
    end

    assign rpt_vec = rpt_hit ? (N_BTN'(1) << rpt_id) : '0;
`else
    logic unused_cfg;

    assign rpt_vec    = '0;
    assign unused_cfg = ^{HOLD_CYCLES, REPEAT_CYCLES, sync_lvl};
`endif

    // Repeat pulses behave exactly like edge pulses from here on. In IDLE the
    // arbiter also sees this cycle's pulses, so a fresh press is offered in
    // the same edge that sets its pending flag.
    assign evt_vec     = edge_vec | rpt_vec;
    assign req_vec     = PENDING | evt_vec;
    assign hs          = (state == ST_OFFER) && EVT_READY;
    assign clr_vec     = hs ? (N_BTN'(1) << EVT_ID) : '0;
    assign drop_vec    = evt_vec & PENDING & ~clr_vec;
    assign pending_nxt = (PENDING & ~clr_vec) | evt_vec;
    assign grant_id    = rr_pick(req_vec, last_grant);

    // Pending flags, grant and drop registers
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            PENDING    <= '0;
            DROP_PULSE <= 1'b0;
            EVT_ID     <= '0;
            last_grant <= ID_W'(N_BTN - 1);
        end else begin
            PENDING    <= pending_nxt;
            DROP_PULSE <= |drop_vec;
            if ((state == ST_IDLE) && (|req_vec)) begin
                EVT_ID <= grant_id;
            end
            if (hs) begin
                last_grant <= EVT_ID;
            end
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (|req_vec)  state_nxt = ST_OFFER;
            ST_OFFER: if (EVT_READY) state_nxt = ST_IDLE;
            default:                 state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        EVT_VALID = 1'b0;
        if (state == ST_OFFER) begin
            EVT_VALID = 1'b1;
        end
    end

endmodule

// File: tb/tb_button_event_arbiter.sv
module tb_button_event_arbiter;

    localparam int N_BTN = 4;
    localparam int ID_W  = 2;

    logic             CLOCK = 1'b0;
    logic             RESET_N;
    logic [N_BTN-1:0] PB;
    logic             EVT_VALID;
    logic [ID_W-1:0]  EVT_ID;
    logic             EVT_READY;
    logic [N_BTN-1:0] PENDING;
    logic             DROP_PULSE;

    int n_tests  = 0;
    int n_fail   = 0;
    int exp_q[$];
    int hs_t[$];
    int cyc      = 0;
    int drop_cnt = 0;

    always #5 CLOCK = ~CLOCK;

    button_event_arbiter #(
        .N_BTN         (N_BTN),
        .ID_W          (ID_W),
        .HOLD_CYCLES   (10),
        .REPEAT_CYCLES (4)
    ) dut (
        .CLOCK      (CLOCK),
        .RESET_N    (RESET_N),
        .PB         (PB),
        .EVT_VALID  (EVT_VALID),
        .EVT_ID     (EVT_ID),
        .EVT_READY  (EVT_READY),
        .PENDING    (PENDING),
        .DROP_PULSE (DROP_PULSE)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge CLOCK);
    endtask

    task automatic wait_valid(input int max_cyc, input string tag);
        int k;
        k = 0;
        while (EVT_VALID !== 1'b1 && k < max_cyc) begin
            step(1);
            k++;
        end
        if (EVT_VALID !== 1'b1) check_val(tag, 32'(EVT_VALID), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge CLOCK);
        RESET_N   = 1'b0;
        PB        = '0;
        EVT_READY = 1'b0;
        step(2);
        RESET_N = 1'b1;
        step(5);
        exp_q.delete();
        hs_t.delete();
    endtask

    // Scoreboard: inputs settle at the negedge, so 1 time unit later both
    // EVT_VALID and EVT_READY hold the values seen by the next rising edge.
    always @(negedge CLOCK) begin
        #1;
        cyc++;
        if (RESET_N === 1'b1) begin
            if (DROP_PULSE === 1'b1) drop_cnt++;
            if (EVT_VALID === 1'b1 && EVT_READY === 1'b1) begin
                hs_t.push_back(cyc);
                check_val("sb_occupancy", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) check_val("evt_id", 32'(EVT_ID), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int h0;
        int bad;

        RESET_N   = 1'b0;
        PB        = '0;
        EVT_READY = 1'b0;
        step(3);
        check_val("rst_valid",   32'(EVT_VALID),  32'd0);
        check_val("rst_id",      32'(EVT_ID),     32'd0);
        check_val("rst_pending", 32'(PENDING),    32'd0);
        check_val("rst_drop",    32'(DROP_PULSE), 32'd0);
        RESET_N = 1'b1;
        step(5);

        // Single press: offer at cycle 4, pending cleared at cycle 5
        EVT_READY = 1'b1;
        PB        = 4'b0001;
        exp_q.push_back(0);
        step(3);
        check_val("single_pre_valid", 32'(EVT_VALID), 32'd0);
        step(1);
        check_val("single_valid", 32'(EVT_VALID), 32'd1);
        check_val("single_id",    32'(EVT_ID),    32'd0);
        check_val("single_pend4", 32'(PENDING),   32'b0001);
        step(1);
        check_val("single_pend5", 32'(PENDING),   32'd0);
        check_val("single_idle",  32'(EVT_VALID), 32'd0);
        PB = '0;
        step(6);
        check_val("single_sb_empty", 32'(exp_q.size()), 32'd0);

        // Simultaneous press from reset: 0,1,2,3 every 2 cycles
        do_reset();
        d0        = drop_cnt;
        EVT_READY = 1'b1;
        PB        = 4'b1111;
        for (int i = 0; i < N_BTN; i++) exp_q.push_back(i);
        step(14);
        check_val("simul_count", 32'(hs_t.size()), 32'd4);
        for (int i = 1; i < hs_t.size(); i++)
            check_val("simul_spacing", 32'(hs_t[i] - hs_t[i-1]), 32'd2);
        check_val("simul_drop", 32'(drop_cnt - d0), 32'd0);
        PB = '0;
        step(5);
        check_val("simul_sb_empty", 32'(exp_q.size()), 32'd0);

        // Backpressure: PB[2] pressed twice while not ready
        EVT_READY = 1'b0;
        d0        = drop_cnt;
        h0        = hs_t.size();
        bad       = 0;
        exp_q.push_back(2);
        for (int k = 0; k < 20; k++) begin
            PB = (k < 4 || (k >= 8 && k < 12)) ? 4'b0100 : 4'b0000;
            step(1);
            if (k >= 3 && (EVT_VALID !== 1'b1 || EVT_ID !== 2'd2)) bad++;
        end
        check_val("bp_stable",  32'(bad), 32'd0);
        check_val("bp_drop",    32'(drop_cnt - d0), 32'd1);
        check_val("bp_no_hs",   32'(hs_t.size()), 32'(h0));
        EVT_READY = 1'b1;
        step(6);
        check_val("bp_one_evt", 32'(hs_t.size()), 32'(h0 + 1));
        check_val("bp_sb_empty", 32'(exp_q.size()), 32'd0);

        // Fairness: grant 3 with 1001 left -> 0; grant 0 with 1001 left -> 3
        EVT_READY = 1'b0;
        d0        = drop_cnt;
        exp_q.push_back(3);
        exp_q.push_back(0);
        exp_q.push_back(3);
        exp_q.push_back(0);
        PB = 4'b1000;
        wait_valid(10, "fair_first_timeout");
        check_val("fair_first", 32'(EVT_ID), 32'd3);
        PB = 4'b1001;
        step(5);
        check_val("fair_setup", 32'(PENDING), 32'b1001);
        PB = '0;
        step(5);
        PB = 4'b1000;
        step(3);
        EVT_READY = 1'b1;
        step(1);
        check_val("fair_pend_a", 32'(PENDING),   32'b1001);
        check_val("fair_idle_a", 32'(EVT_VALID), 32'd0);
        EVT_READY = 1'b0;
        PB        = '0;
        step(1);
        check_val("fair_valid_a", 32'(EVT_VALID), 32'd1);
        check_val("fair_next_a",  32'(EVT_ID),    32'd0);
        step(4);
        PB = 4'b0001;
        step(3);
        EVT_READY = 1'b1;
        step(1);
        check_val("fair_pend_b", 32'(PENDING), 32'b1001);
        PB = '0;
        step(1);
        check_val("fair_next_b", 32'(EVT_ID), 32'd3);
        step(6);
        check_val("fair_drop",     32'(drop_cnt - d0), 32'd0);
        check_val("fair_sb_empty", 32'(exp_q.size()), 32'd0);

        // Reset in OFFER with 0110 pending, buttons held through release
        EVT_READY = 1'b0;
        PB        = 4'b0110;
        wait_valid(10, "rst_offer_timeout");
        step(1);
        check_val("rst_mid_setup", 32'(PENDING), 32'b0110);
        #2 RESET_N = 1'b0;
        #1;
        check_val("rst_mid_valid",   32'(EVT_VALID),  32'd0);
        check_val("rst_mid_id",      32'(EVT_ID),     32'd0);
        check_val("rst_mid_pending", 32'(PENDING),    32'd0);
        check_val("rst_mid_drop",    32'(DROP_PULSE), 32'd0);
        d0 = drop_cnt;
        h0 = hs_t.size();
        @(negedge CLOCK);
        RESET_N   = 1'b1;
        EVT_READY = 1'b1;
        step(15);
        check_val("rst_hold_no_evt",  32'(hs_t.size()), 32'(h0));
        check_val("rst_hold_no_drop", 32'(drop_cnt - d0), 32'd0);
        check_val("rst_hold_pending", 32'(PENDING), 32'd0);
        PB = '0;
        step(5);

        // PB[1] held 30 cycles with the consumer always ready
        hs_t.delete();
        EVT_READY = 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
        repeat (6) exp_q.push_back(1);
        PB = 4'b0010;
        step(30);
        PB = '0;
        step(20);
        check_val("rpt_count", 32'(hs_t.size()), 32'd6);
        for (int i = 1; i < hs_t.size(); i++)
            check_val("rpt_gap", 32'(hs_t[i] - hs_t[i-1]), (i == 1) ? 32'd10 : 32'd4);
`else
        exp_q.push_back(1);
        PB = 4'b0010;
        step(30);
        PB = '0;
        step(20);
        check_val("norpt_count", 32'(hs_t.size()), 32'd1);
`endif
        check_val("hold_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
